// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the programmable timer peripheral.
package prog_timer_pkg;

  // Tick base select codes
  typedef enum logic [1:0] {
    BASE_MS    = 2'b00,
    BASE_TENTH = 2'b01,
    BASE_SEC   = 2'b10,
    BASE_MIN   = 2'b11
  } base_e;

  // Completion behaviour
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Channel FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Per-channel configuration payload
  typedef struct packed {
    base_e base;
    mode_e mode;
  } ch_cfg_t;

  // Cascade ratios of the time base
  localparam int unsigned MS_PER_TENTH  = 100;
  localparam int unsigned TENTH_PER_SEC = 10;
  localparam int unsigned SEC_PER_MIN   = 60;

  // Tick vector layout: {min, sec, tenth, ms}
  localparam int unsigned N_TICKS = 4;

  // Pick the tick matching a channel's base
  function automatic logic sel_tick(input base_e base, input logic [N_TICKS-1:0] ticks);
    logic t;
    t = 1'b0;
    case (base)
      BASE_MS:    t = ticks[0];
      BASE_TENTH: t = ticks[1];
      BASE_SEC:   t = ticks[2];
      BASE_MIN:   t = ticks[3];
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prog_timer_time_base.sv
// Shared time base: cascaded prescalers producing ms / tenth-s / s / min ticks.
module prog_timer_time_base
  import prog_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 24_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic ms_tick_o,
  output logic tenth_tick_o,
  output logic sec_tick_o,
  output logic min_tick_o
);

  localparam int unsigned DIV   = CLK_HZ / 1000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MS_W  = $clog2(MS_PER_TENTH);
  localparam int unsigned TN_W  = $clog2(TENTH_PER_SEC);
  localparam int unsigned SC_W  = $clog2(SEC_PER_MIN);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [TN_W-1:0]  tn_cnt_q, tn_cnt_d;
  logic [SC_W-1:0]  sc_cnt_q, sc_cnt_d;
  logic ms_c, tenth_c, sec_c, min_c;

  // Terminal-count detection and counter advance; coincident ticks share a cycle
  always_comb begin
    ms_c     = (pre_q == PRE_W'(DIV - 1));
    tenth_c  = ms_c && (ms_cnt_q == MS_W'(MS_PER_TENTH - 1));
    sec_c    = tenth_c && (tn_cnt_q == TN_W'(TENTH_PER_SEC - 1));
    min_c    = sec_c && (sc_cnt_q == SC_W'(SEC_PER_MIN - 1));
    pre_d    = ms_c ? '0 : pre_q + PRE_W'(1);
    ms_cnt_d = ms_cnt_q;
    tn_cnt_d = tn_cnt_q;
    sc_cnt_d = sc_cnt_q;
    if (ms_c)    ms_cnt_d = tenth_c ? '0 : ms_cnt_q + MS_W'(1);
    if (tenth_c) tn_cnt_d = sec_c   ? '0 : tn_cnt_q + TN_W'(1);
    if (sec_c)   sc_cnt_d = min_c   ? '0 : sc_cnt_q + SC_W'(1);
  end

  // Counter state and registered tick outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      ms_cnt_q     <= '0;
      tn_cnt_q     <= '0;
      sc_cnt_q     <= '0;
      ms_tick_o    <= 1'b0;
      tenth_tick_o <= 1'b0;
      sec_tick_o   <= 1'b0;
      min_tick_o   <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      ms_cnt_q     <= ms_cnt_d;
      tn_cnt_q     <= tn_cnt_d;
      sc_cnt_q     <= sc_cnt_d;
      ms_tick_o    <= ms_c;
      tenth_tick_o <= tenth_c;
      sec_tick_o   <= sec_c;
      min_tick_o   <= min_c;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: shared time base plus N_CH tick-counting channels.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 24_000_000,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 6,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [CH_W-1:0]  wch,
  input  logic [1:0]       wbase,
  input  logic             wmode,
  input  logic [CNT_W-1:0] wumbral,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  input  logic [N_CH-1:0]  clr,
  input  logic [CH_W-1:0]  rch,
  output logic [CNT_W-1:0] rcount,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  timer_end,
  output logic [N_CH-1:0]  end_pulse
);

  localparam int unsigned N_RD = 1 << CH_W;
  localparam int unsigned CW1  = CNT_W + 1;

  logic ms_tick, tenth_tick, sec_tick, min_tick;
  logic [N_TICKS-1:0] ticks;
  logic [CNT_W-1:0] cnt_arr [N_RD];

  prog_timer_time_base #(
    .CLK_HZ(CLK_HZ)
  ) u_time_base (
    .clk          (clk),
    .reset        (reset),
    .ms_tick_o    (ms_tick),
    .tenth_tick_o (tenth_tick),
    .sec_tick_o   (sec_tick),
    .min_tick_o   (min_tick)
  );

  assign ticks = {min_tick, sec_tick, tenth_tick, ms_tick};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    ch_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] umbral_q, umbral_d;
    logic             end_q, end_d;
    logic             pulse_q, pulse_d;
    logic             wsel_c, tick_c, done_c;

    // Writes to channels beyond N_CH never match any instance
    assign wsel_c = we && (wch == CH_W'(i));
    assign tick_c = sel_tick(cfg_q.base, ticks);

    // Channel next state: stop > start > tick, clr > completion for the sticky flag
    always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      cnt_d    = cnt_q;
      umbral_d = umbral_q;
      end_d    = end_q;
      pulse_d  = 1'b0;
      done_c   = 1'b0;
      if (wsel_c) begin
        cfg_d    = '{base: base_e'(wbase), mode: mode_e'(wmode)};
        umbral_d = wumbral;
      end
      if (stop[i]) begin
        state_d = S_IDLE;
      end else if (start[i]) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else if (state_q == S_RUN) begin
        if ((umbral_q == '0) ||
            (tick_c && ((CW1'(cnt_q) + CW1'(1)) >= CW1'(umbral_q)))) begin
          done_c  = 1'b1;
          pulse_d = 1'b1;
          if (cfg_q.mode == MODE_PERIODIC) begin
            cnt_d = '0;
          end else begin
            state_d = S_DONE;
            cnt_d   = umbral_q;
          end
        end else if (tick_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (clr[i]) end_d = 1'b0;
      else if (done_c) end_d = 1'b1;
    end

    // Channel state register
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cfg_q    <= '{base: BASE_MS, mode: MODE_ONESHOT};
        cnt_q    <= '0;
        umbral_q <= '0;
        end_q    <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        cfg_q    <= cfg_d;
        cnt_q    <= cnt_d;
        umbral_q <= umbral_d;
        end_q    <= end_d;
        pulse_q  <= pulse_d;
      end
    end

    assign running[i]   = (state_q == S_RUN);
    assign timer_end[i] = end_q;
    assign end_pulse[i] = pulse_q;
    assign cnt_arr[i]   = cnt_q;
  end

  // Unpopulated read slots return zero
  for (genvar p = N_CH; p < N_RD; p++) begin : g_pad
    assign cnt_arr[p] = '0;
  end

  assign rcount = cnt_arr[rch];

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer at CLK_HZ=4000 (ms tick every 4 clks).
module tb_prog_timer;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             we;
  logic [1:0]       wch;
  logic [1:0]       wbase;
  logic             wmode;
  logic [CNT_W-1:0] wumbral;
  logic [N_CH-1:0]  start, stop, clr;
  logic [1:0]       rch;
  logic [CNT_W-1:0] rcount;
  logic [N_CH-1:0]  running, timer_end, end_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  prog_timer #(
    .CLK_HZ(4000),
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wch       (wch),
    .wbase     (wbase),
    .wmode     (wmode),
    .wumbral   (wumbral),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .rch       (rch),
    .rcount    (rcount),
    .running   (running),
    .timer_end (timer_end),
    .end_pulse (end_pulse)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ms ticks are visible when cyc % 4 == 0
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    if (cyc > n) chk("schedule", 32'(cyc), 32'(n));
    while (cyc < n) step();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] base, input logic mode,
                     input logic [CNT_W-1:0] umb);
    wch = ch; wbase = base; wmode = mode; wumbral = umb; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic do_start(input logic [N_CH-1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic rd(input logic [1:0] ch);
    rch = ch;
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wch = '0; wbase = '0; wmode = 1'b0; wumbral = '0;
    start = '0; stop = '0; clr = '0; rch = '0;

    // Reset state
    step(); step();
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_timer_end", 32'(timer_end), 32'h0);
    chk("rst_end_pulse", 32'(end_pulse), 32'h0);
    chk("rst_rcount", 32'(rcount), 32'h0);
    reset = 1'b0;

    // One-shot, ch0 on ms, umbral 3
    wait_cyc(18); cfg(2'd0, 2'b00, 1'b0, 6'd3);
    wait_cyc(20); do_start(4'b0001);
    chk("os_running", 32'(running), 32'h1);
    wait_cyc(29); rd(2'd0);
    chk("os_cnt2", 32'(rcount), 32'd2);
    wait_cyc(32);
    chk("os_no_pulse_yet", 32'(end_pulse), 32'h0);
    step();
    chk("os_pulse", 32'(end_pulse), 32'h1);
    chk("os_stopped", 32'(running), 32'h0);
    chk("os_sticky", 32'(timer_end), 32'h1);
    chk("os_cnt_hold", 32'(rcount), 32'd3);
    step();
    chk("os_pulse_1cyc", 32'(end_pulse), 32'h0);
    chk("os_sticky_hold", 32'(timer_end), 32'h1);
    wait_cyc(36); clr = 4'b0001; step(); clr = '0;
    chk("os_clr", 32'(timer_end), 32'h0);

    // Periodic, ch1 on tenth-s, umbral 2: completions after ticks at 800/1600/2400
    wait_cyc(40); cfg(2'd1, 2'b01, 1'b1, 6'd2);
    wait_cyc(50); do_start(4'b0010);
    wait_cyc(401); rd(2'd1);
    chk("per_cnt1", 32'(rcount), 32'd1);
    wait_cyc(800);
    chk("per_no_pulse", 32'(end_pulse), 32'h0);
    step();
    chk("per_pulse1", 32'(end_pulse), 32'h2);
    chk("per_run1", 32'(running), 32'h2);
    chk("per_wrap1", 32'(rcount), 32'd0);
    step();
    chk("per_pulse1_end", 32'(end_pulse), 32'h0);
    wait_cyc(1601);
    chk("per_pulse2", 32'(end_pulse), 32'h2);
    wait_cyc(2401);
    chk("per_pulse3", 32'(end_pulse), 32'h2);
    chk("per_run3", 32'(running), 32'h2);
    wait_cyc(2410); stop = 4'b0010; step(); stop = '0;
    chk("per_stopped", 32'(running), 32'h0);

    // Collisions on ch2 (ms, one-shot, umbral 2)
    wait_cyc(2420); cfg(2'd2, 2'b00, 1'b0, 6'd2);
    wait_cyc(2422); do_start(4'b0100);
    wait_cyc(2425); stop = 4'b0100; start = 4'b0100; step(); stop = '0; start = '0;
    rd(2'd2);
    chk("col_stop_start_idle", 32'(running), 32'h0);
    chk("col_cnt_hold", 32'(rcount), 32'd1);
    wait_cyc(2430); do_start(4'b0100);
    wait_cyc(2436); clr = 4'b0100; step(); clr = '0;
    chk("col_clr_pulse", 32'(end_pulse), 32'h4);
    chk("col_clr_wins", 32'(timer_end), 32'h2);

    // Corner: umbral 0 on ch3 completes 2 clks after start
    wait_cyc(2450); cfg(2'd3, 2'b00, 1'b0, 6'd0);
    wait_cyc(2452); do_start(4'b1000);
    chk("u0_first_run", 32'(end_pulse), 32'h0);
    step();
    chk("u0_pulse", 32'(end_pulse), 32'h8);
    chk("u0_done", 32'(running), 32'h0);

    // Corner: lower umbral 10 -> 2 while cnt = 5
    wait_cyc(2460); cfg(2'd3, 2'b00, 1'b0, 6'd10);
    wait_cyc(2462); do_start(4'b1000);
    wait_cyc(2482); cfg(2'd3, 2'b00, 1'b0, 6'd2);
    rd(2'd3);
    chk("low_cnt5", 32'(rcount), 32'd5);
    chk("low_running", 32'(running), 32'h8);
    wait_cyc(2485);
    chk("low_pulse", 32'(end_pulse), 32'h8);
    chk("low_cnt_umbral", 32'(rcount), 32'd2);
    chk("low_done", 32'(running), 32'h0);

    // Concurrency: periodic umbral 1 on ms / tenth / s / min
    wait_cyc(2490);
    cfg(2'd0, 2'b00, 1'b1, 6'd1);
    cfg(2'd1, 2'b01, 1'b1, 6'd1);
    cfg(2'd2, 2'b10, 1'b1, 6'd1);
    cfg(2'd3, 2'b11, 1'b1, 6'd1);
    wait_cyc(2500); do_start(4'b1111);
    chk("cc_running", 32'(running), 32'hF);
    chk("cc_start_keeps_end", 32'(timer_end), 32'hA);
    wait_cyc(2504);
    chk("cc_no_pulse", 32'(end_pulse), 32'h0);
    step();
    chk("cc_ms_pulse", 32'(end_pulse), 32'h1);
    step();
    chk("cc_ms_gap", 32'(end_pulse), 32'h0);
    wait_cyc(2801);
    chk("cc_tenth_pulse", 32'(end_pulse), 32'h3);
    wait_cyc(4000);
    chk("cc_pre_sec", 32'(end_pulse), 32'h0);
    step();
    chk("cc_sec_pulse", 32'(end_pulse), 32'h7);
    chk("cc_min_running", 32'(running), 32'hF);
    chk("cc_end_all", 32'(timer_end), 32'hF);

    // Mid-operation reset on a would-be completion cycle
    wait_cyc(4004); reset = 1'b1; rd(2'd0); step();
    chk("mrst_running", 32'(running), 32'h0);
    chk("mrst_no_pulse", 32'(end_pulse), 32'h0);
    chk("mrst_end", 32'(timer_end), 32'h0);
    chk("mrst_cnt", 32'(rcount), 32'd0);
    step(); reset = 1'b0; step();
    chk("mrst_idle", 32'(running), 32'h0);
    chk("mrst_idle_pulse", 32'(end_pulse), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
